// File: rtl/motor_ramp_if.sv
// Speed-command handshake between the motion controller and one motor_ramp channel.
// The controller side uses the master modport; motor_ramp uses the slave modport.
interface motor_ramp_if #(
  parameter int WL = 13
) ();
  logic signed [WL:0] i_cmd_speed;
  logic               i_cmd_valid;
  logic               o_cmd_ready;

  modport master (
    output i_cmd_speed,
    output i_cmd_valid,
    input  o_cmd_ready
  );

  modport slave (
    input  i_cmd_speed,
    input  i_cmd_valid,
    output o_cmd_ready
  );
endinterface

// File: rtl/motor_ramp.sv
// Speed-command conditioner ahead of the PWM stage: slews duty toward the commanded
// magnitude and sequences direction reversals through zero duty and a dead-time dwell.
module motor_ramp #(
  parameter int CLK_FREQ = 100000000,
  parameter int PWM_FREQ = 20000,
  parameter int WL       = $clog2(CLK_FREQ / PWM_FREQ),
  parameter int RAMP_DIV = 10000,
  parameter int STEP     = 5,
  parameter int DEADTIME = 100000
) (
  input  logic          clk,
  input  logic          reset_n,
  motor_ramp_if.slave   cmd,
  input  logic          i_brake,
  output logic [WL-1:0] o_duty_cycle,
  output logic          o_dir,
  output logic          o_at_target
);

  localparam int MAX_DUTY = CLK_FREQ / PWM_FREQ;
  localparam int PW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DW       = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

  localparam logic [WL:0]   MAX_W  = (WL+1)'(MAX_DUTY);
  localparam logic [WL:0]   STEP_W = (WL+1)'(STEP);
  localparam logic [WL:0]   ONE_W  = (WL+1)'(1);
  localparam logic [PW-1:0] TICK_W = PW'(RAMP_DIV - 1);
  localparam logic [DW-1:0] DWELL_W = DW'(DEADTIME - 1);

  typedef enum logic [1:0] {
    HOLD,
    RAMP,
    DWELL
  } state_t;

  state_t        state_q, state_d;
  logic [WL-1:0] duty_q, duty_d;
  logic          dir_q, dir_d;
  logic [WL-1:0] tgt_mag_q, tgt_mag_d;
  logic          tgt_dir_q, tgt_dir_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          ready_q, ready_d;
  logic          at_target_q, at_target_d;

  logic          tick;
  logic          accept;
  logic          same_dir;
  logic          at_goal;
  logic [WL:0]   cmd_raw;
  logic [WL:0]   cmd_abs;
  logic [WL:0]   cmd_mag;
  logic [WL:0]   duty_ext;
  logic [WL:0]   tgt_ext;
  logic [WL:0]   toward_tgt;
  logic [WL:0]   toward_zero;

  assign o_duty_cycle    = duty_q;
  assign o_dir           = dir_q;
  assign o_at_target     = at_target_q;
  assign cmd.o_cmd_ready = ready_q;

  // Magnitude is taken one bit wider than the duty so the most-negative command cannot overflow.
  always_comb begin
    cmd_raw = cmd.i_cmd_speed;
    cmd_abs = cmd_raw[WL] ? (~cmd_raw + ONE_W) : cmd_raw;
    cmd_mag = (cmd_abs > MAX_W) ? MAX_W : cmd_abs;
  end

  always_comb begin
    duty_ext = {1'b0, duty_q};
    tgt_ext  = {1'b0, tgt_mag_q};

    if (duty_ext < tgt_ext) begin
      toward_tgt = ((tgt_ext - duty_ext) <= STEP_W) ? tgt_ext : (duty_ext + STEP_W);
    end else begin
      toward_tgt = ((duty_ext - tgt_ext) <= STEP_W) ? tgt_ext : (duty_ext - STEP_W);
    end

    toward_zero = (duty_ext <= STEP_W) ? '0 : (duty_ext - STEP_W);
  end

  assign tick     = (presc_q == TICK_W);
  assign accept   = cmd.i_cmd_valid && ready_q && !i_brake && (state_q != DWELL);
  assign same_dir = (dir_q == tgt_dir_q) || (tgt_mag_q == '0);
  assign at_goal  = (duty_q == tgt_mag_q) && same_dir;

  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    dir_d     = dir_q;
    tgt_mag_d = tgt_mag_q;
    tgt_dir_d = tgt_dir_q;
    presc_d   = tick ? '0 : (presc_q + PW'(1));
    dwell_d   = dwell_q;

    if (accept) begin
      tgt_mag_d = cmd_mag[WL-1:0];
      tgt_dir_d = cmd_raw[WL];
    end

    case (state_q)
      HOLD: begin
        if (!at_goal) begin
          state_d = RAMP;
        end
      end

      RAMP: begin
        if (same_dir) begin
          if (duty_q == tgt_mag_q) begin
            state_d = HOLD;
          end else if (tick) begin
            duty_d = toward_tgt[WL-1:0];
            if (toward_tgt == tgt_ext) begin
              state_d = HOLD;
            end
          end
        end else if (tick) begin
          // A reversal only commits to the dwell once a tick finds the bridge at zero duty.
          if (duty_q == '0) begin
            state_d = DWELL;
            dwell_d = DWELL_W;
          end else begin
            duty_d = toward_zero[WL-1:0];
          end
        end
      end

      DWELL: begin
        duty_d = '0;
        if (dwell_q == '0) begin
          dir_d   = tgt_dir_q;
          state_d = RAMP;
        end else begin
          dwell_d = dwell_q - DW'(1);
        end
      end

      default: begin
        state_d = HOLD;
      end
    endcase

    // Brake overrides everything except the direction pin, which stays where it was.
    if (i_brake) begin
      duty_d    = '0;
      tgt_mag_d = '0;
      state_d   = HOLD;
      presc_d   = '0;
      dwell_d   = '0;
    end

    ready_d     = !i_brake && (state_d != DWELL);
    at_target_d = (state_d == HOLD) && (duty_d == tgt_mag_d) &&
                  ((tgt_mag_d == '0) || (dir_d == tgt_dir_d));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HOLD;
      duty_q      <= '0;
      dir_q       <= 1'b0;
      tgt_mag_q   <= '0;
      tgt_dir_q   <= 1'b0;
      presc_q     <= '0;
      dwell_q     <= '0;
      ready_q     <= 1'b1;
      at_target_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      dir_q       <= dir_d;
      tgt_mag_q   <= tgt_mag_d;
      tgt_dir_q   <= tgt_dir_d;
      presc_q     <= presc_d;
      dwell_q     <= dwell_d;
      ready_q     <= ready_d;
      at_target_q <= at_target_d;
    end
  end

endmodule
